// File: rtl/dmem_store_tracer.sv
// Passive tracer on the processor-to-DMEM bus: committed stores that hit the watch
// window go into a FWFT FIFO. Optional capture timestamp via STORE_TRACER_TIMESTAMP_EN.
module dmem_store_tracer #(
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] WATCH_BASE = 32'h0000_2000,
  parameter logic [31:0] WATCH_MASK = 32'hFFFF_F000,
  parameter int unsigned TS_WIDTH   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             addr_to_mem,
  input  logic [31:0]             data_to_mem,
  input  logic                    write_enable_to_mem,
  input  logic                    byte_to_mem,
  input  logic                    half_word_to_mem,
  input  logic                    trace_enable,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_addr,
  output logic [31:0]             out_data,
  output logic [1:0]              out_size,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [15:0]             drop_count,
`ifdef STORE_TRACER_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]     out_timestamp,
`endif
  input  logic                    clear_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_param_check
    $error("dmem_store_tracer: DEPTH must be a power of two >= 2 and TS_WIDTH >= 1");
  end

  logic [31:0]   mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [1:0]    mem_size [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          hit, full, pop, push, drop;
  logic [31:0]   cap_data;
  logic [1:0]    cap_size;

  assign hit  = write_enable_to_mem & trace_enable & ((addr_to_mem & WATCH_MASK) == WATCH_BASE);
  assign full = (count == FULL_COUNT);
  assign pop  = out_valid & out_ready;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push = hit & (~full | pop);
  assign drop = hit & full & ~pop;

  // processor numbers bits MSB-first, so its bits [24:31] are the low byte here
  always_comb begin
    cap_data = data_to_mem;
    cap_size = 2'b00;
    if (byte_to_mem) begin
      cap_data = {24'h0, data_to_mem[7:0]};
      cap_size = 2'b10;
    end else if (half_word_to_mem) begin
      cap_data = {16'h0, data_to_mem[15:0]};
      cap_size = 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr] <= addr_to_mem;
      mem_data[wr_ptr] <= cap_data;
      mem_size[wr_ptr] <= cap_size;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      if (clear_overflow)              drop_count <= 16'd1;
      else if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  assign out_valid = (count != '0);

  always_comb begin
    out_addr = '0;
    out_data = '0;
    out_size = '0;
    if (out_valid) begin
      out_addr = mem_addr[rd_ptr];
      out_data = mem_data[rd_ptr];
      out_size = mem_size[rd_ptr];
    end
  end

`ifdef STORE_TRACER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] mem_ts [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (push) mem_ts[wr_ptr] <= ts_cnt;
  end

  assign out_timestamp = out_valid ? mem_ts[rd_ptr] : '0;
`endif

endmodule
